// File: rtl/pipe_scoreboard.sv
// Register scoreboard for the in-order pipeline: issue interlock, bypass select, flush undo, drain status.
// Define SB_WAW_CHECK_EN to stall a write that would complete before an older pending write to the same rd.
module pipe_scoreboard #(
    parameter  int NREG  = 32,
    parameter  int LAT_W = 4,
    parameter  int CNT_W = 6,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rs1,
    input  logic             iss_rs1_en,
    input  logic [AW-1:0]    iss_rs2,
    input  logic             iss_rs2_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             iss_wen,
    input  logic [LAT_W-1:0] iss_lat,
    output logic             iss_stall,
    output logic             rs1_fwd,
    output logic             rs2_fwd,
    input  logic             kill,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    output logic [CNT_W-1:0] busy_cnt,
    output logic             drained
);

    logic [NREG-1:0]  r_busy;
    logic [LAT_W-1:0] r_cnt [NREG];
    logic             r_undo_valid;
    logic [AW-1:0]    r_undo_rd;
    logic             r_undo_busy;
    logic [LAT_W-1:0] r_undo_cnt;
    logic [CNT_W-1:0] r_busy_cnt;
    logic             r_drained;

    logic [LAT_W-1:0] w_lat;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_waw;
    logic             w_stall;
    logic             w_accept;
    logic             w_wr;
    logic             w_restore_busy;
    logic [LAT_W-1:0] w_undo_dec;
    logic [NREG-1:0]  w_busy_nxt;
    logic [LAT_W-1:0] w_cnt_nxt [NREG];
    logic [CNT_W-1:0] w_busy_cnt_nxt;

    assign w_lat = (iss_lat == '0) ? LAT_W'(1) : iss_lat;

    assign w_haz1 = iss_rs1_en && (iss_rs1 != '0) && r_busy[iss_rs1] && (r_cnt[iss_rs1] != '0);
    assign w_haz2 = iss_rs2_en && (iss_rs2 != '0) && r_busy[iss_rs2] && (r_cnt[iss_rs2] != '0);

    assign rs1_fwd = iss_rs1_en && (iss_rs1 != '0) && r_busy[iss_rs1] && (r_cnt[iss_rs1] == '0);
    assign rs2_fwd = iss_rs2_en && (iss_rs2 != '0) && r_busy[iss_rs2] && (r_cnt[iss_rs2] == '0);

`ifdef SB_WAW_CHECK_EN
    assign w_waw = iss_wen && (iss_rd != '0) && r_busy[iss_rd] && (r_cnt[iss_rd] >= w_lat);
`else
    assign w_waw = 1'b0;
`endif

    assign w_stall   = iss_valid && (w_haz1 || w_haz2 || w_waw);
    assign iss_stall = w_stall;
    assign w_accept  = iss_valid && !w_stall && !kill;
    assign w_wr      = w_accept && iss_wen && (iss_rd != '0);

    // A squashed issue restores the pre-issue state, but a writeback landing in the
    // kill cycle still retires the register.
    assign w_restore_busy = r_undo_busy && !(wb_valid && (wb_rd == r_undo_rd));
    assign w_undo_dec     = (r_undo_cnt != '0) ? r_undo_cnt - LAT_W'(1) : '0;

    // cnt holds the cycles still to wait as seen by a reader in the following cycle,
    // so the issue edge loads lat-1: an ALU result (lat=1) is forwardable immediately.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_cnt_nxt[i] = (r_cnt[i] != '0) ? r_cnt[i] - LAT_W'(1) : '0;
        end
        if (wb_valid && (wb_rd != '0)) begin
            w_busy_nxt[wb_rd] = 1'b0;
            w_cnt_nxt[wb_rd]  = '0;
        end
        if (kill && r_undo_valid) begin
            w_busy_nxt[r_undo_rd] = w_restore_busy;
            w_cnt_nxt[r_undo_rd]  = w_restore_busy ? w_undo_dec : '0;
        end
        if (w_wr) begin
            w_busy_nxt[iss_rd] = 1'b1;
            w_cnt_nxt[iss_rd]  = w_lat - LAT_W'(1);
        end
        w_busy_nxt[0] = 1'b0;
        w_cnt_nxt[0]  = '0;
    end

    always_comb begin
        w_busy_cnt_nxt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_busy_cnt_nxt = w_busy_cnt_nxt + CNT_W'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= '0;
            r_cnt        <= '{default: '0};
            r_undo_valid <= 1'b0;
            r_undo_rd    <= '0;
            r_undo_busy  <= 1'b0;
            r_undo_cnt   <= '0;
            r_busy_cnt   <= '0;
            r_drained    <= 1'b1;
        end else begin
            r_busy       <= w_busy_nxt;
            r_cnt        <= w_cnt_nxt;
            r_undo_valid <= w_wr;
            r_undo_rd    <= iss_rd;
            r_undo_busy  <= r_busy[iss_rd];
            r_undo_cnt   <= r_cnt[iss_rd];
            r_busy_cnt   <= w_busy_cnt_nxt;
            r_drained    <= (w_busy_cnt_nxt == '0);
        end
    end

    assign busy_cnt = r_busy_cnt;
    assign drained  = r_drained;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Bench for pipe_scoreboard: directed vector table, multi-cycle sequences, random run vs. ready-time model.
`timescale 1ns/1ps
module tb_pipe_scoreboard;
    localparam int NREG  = 32;
    localparam int LAT_W = 4;
    localparam int CNT_W = 6;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             iss_valid;
    logic [AW-1:0]    iss_rs1;
    logic             iss_rs1_en;
    logic [AW-1:0]    iss_rs2;
    logic             iss_rs2_en;
    logic [AW-1:0]    iss_rd;
    logic             iss_wen;
    logic [LAT_W-1:0] iss_lat;
    logic             iss_stall;
    logic             rs1_fwd;
    logic             rs2_fwd;
    logic             kill;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic [CNT_W-1:0] busy_cnt;
    logic             drained;

    always #5 clk = ~clk;

    pipe_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .iss_valid(iss_valid),
        .iss_rs1(iss_rs1), .iss_rs1_en(iss_rs1_en), .iss_rs2(iss_rs2), .iss_rs2_en(iss_rs2_en),
        .iss_rd(iss_rd), .iss_wen(iss_wen), .iss_lat(iss_lat), .iss_stall(iss_stall),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .kill(kill), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .busy_cnt(busy_cnt), .drained(drained)
    );

    typedef struct {
        logic v; logic [AW-1:0] rs1; logic e1; logic [AW-1:0] rs2; logic e2;
        logic [AW-1:0] rd; logic w; logic [LAT_W-1:0] lat; logic kill;
        logic wbv; logic [AW-1:0] wbrd; logic rst;
    } stim_t;

    typedef struct { stim_t s; int x_stall; int x_f1; int x_f2; int x_bc; } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] c_stall, c_f1, c_f2, c_bc, c_dr;

    // Reference model: each busy register remembers the absolute cycle its value reaches the bypass.
    bit m_busy [NREG];
    int m_ready [NREG];
    int m_t = 0;
    int m_uv = 0, m_urd = 0, m_ubusy = 0, m_urem = 0;

    function automatic stim_t mk(int v, int rs1, int e1, int rs2, int e2, int rd, int w, int lat,
                                 int k, int wbv, int wbrd, int rst);
        stim_t s;
        s.v = v[0]; s.rs1 = AW'(rs1); s.e1 = e1[0]; s.rs2 = AW'(rs2); s.e2 = e2[0];
        s.rd = AW'(rd); s.w = w[0]; s.lat = LAT_W'(lat); s.kill = k[0];
        s.wbv = wbv[0]; s.wbrd = AW'(wbrd); s.rst = rst[0];
        return s;
    endfunction

    function automatic vec_t mkv(stim_t s, int st, int f1, int f2, int bc);
        vec_t x;
        x.s = s; x.x_stall = st; x.x_f1 = f1; x.x_f2 = f2; x.x_bc = bc;
        return x;
    endfunction

    function automatic int rem(int r);
        return (m_ready[r] > m_t) ? m_ready[r] - m_t : 0;
    endfunction

    function automatic int m_count();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_comb(input stim_t s, output int st, output int f1, output int f2, output int acc);
        int lat, h1, h2, waw;
        lat = (s.lat == 0) ? 1 : int'(s.lat);
        h1  = (s.e1 && s.rs1 != 0 && m_busy[int'(s.rs1)] && rem(int'(s.rs1)) > 0) ? 1 : 0;
        h2  = (s.e2 && s.rs2 != 0 && m_busy[int'(s.rs2)] && rem(int'(s.rs2)) > 0) ? 1 : 0;
        f1  = (s.e1 && s.rs1 != 0 && m_busy[int'(s.rs1)] && rem(int'(s.rs1)) == 0) ? 1 : 0;
        f2  = (s.e2 && s.rs2 != 0 && m_busy[int'(s.rs2)] && rem(int'(s.rs2)) == 0) ? 1 : 0;
        waw = 0;
`ifdef SB_WAW_CHECK_EN
        if (s.w && s.rd != 0 && m_busy[int'(s.rd)] && rem(int'(s.rd)) >= lat) waw = 1;
`endif
        st  = (s.v && (h1 != 0 || h2 != 0 || waw != 0)) ? 1 : 0;
        acc = (s.v && st == 0 && !s.kill) ? 1 : 0;
    endtask

    task automatic model_edge(input stim_t s, input int acc);
        int lat, rd, wr, pb, pr, wbr;
        lat = (s.lat == 0) ? 1 : int'(s.lat);
        rd  = int'(s.rd);
        wbr = int'(s.wbrd);
        if (s.rst) begin
            foreach (m_busy[i]) begin m_busy[i] = 0; m_ready[i] = 0; end
            m_uv = 0;
        end else begin
            wr = (acc != 0 && s.w && rd != 0) ? 1 : 0;
            pb = int'(m_busy[rd]);
            pr = rem(rd);
            if (s.wbv && wbr != 0) begin m_busy[wbr] = 0; m_ready[wbr] = 0; end
            if (s.kill && m_uv != 0) begin
                m_busy[m_urd]  = (m_ubusy != 0) && !(s.wbv && wbr == m_urd);
                m_ready[m_urd] = m_busy[m_urd] ? m_t + 1 + ((m_urem > 1) ? m_urem - 1 : 0) : 0;
            end
            if (wr != 0) begin m_busy[rd] = 1; m_ready[rd] = m_t + lat; end
            m_uv = wr; m_urd = rd; m_ubusy = pb; m_urem = pr;
        end
        m_t++;
    endtask

    int e_stall, e_f1, e_f2, e_acc;

    task automatic cyc(input stim_t s);
        @(negedge clk);
        reset = s.rst; iss_valid = s.v; iss_rs1 = s.rs1; iss_rs1_en = s.e1;
        iss_rs2 = s.rs2; iss_rs2_en = s.e2; iss_rd = s.rd; iss_wen = s.w; iss_lat = s.lat;
        kill = s.kill; wb_valid = s.wbv; wb_rd = s.wbrd;
        #1;
        c_stall = 32'(iss_stall); c_f1 = 32'(rs1_fwd); c_f2 = 32'(rs2_fwd);
        model_comb(s, e_stall, e_f1, e_f2, e_acc);
        model_edge(s, e_acc);
        @(posedge clk);
        #1;
        c_bc = 32'(busy_cnt); c_dr = 32'(drained);
    endtask

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic stim_t wb(int r);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[$];

    initial begin
        int n, got, exp_n;
        stim_t s;

        reset = 1'b1; iss_valid = 0; iss_rs1 = '0; iss_rs1_en = 0; iss_rs2 = '0; iss_rs2_en = 0;
        iss_rd = '0; iss_wen = 0; iss_lat = '0; kill = 0; wb_valid = 0; wb_rd = '0;

        // fields: v rs1 e1 rs2 e2 rd w lat kill wbv wbrd rst | stall f1 f2 busy_cnt-after-edge
        tbl.push_back(mkv(mk(1, 1, 1, 0, 0, 5, 1, 2, 0, 0, 0, 0), 0, 0, 0, 1));  // lw x5
        tbl.push_back(mkv(mk(1, 5, 1, 1, 1, 6, 1, 1, 0, 0, 0, 0), 1, 0, 0, 1));  // load-use stall
        tbl.push_back(mkv(mk(1, 5, 1, 1, 1, 6, 1, 1, 0, 0, 0, 0), 0, 1, 0, 2));
        tbl.push_back(mkv(wb(5), 0, 0, 0, 1));
        tbl.push_back(mkv(wb(6), 0, 0, 0, 0));
        tbl.push_back(mkv(mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0), 0, 0, 0, 1));  // add x3
        tbl.push_back(mkv(mk(1, 3, 1, 3, 1, 4, 1, 1, 0, 0, 0, 0), 0, 1, 1, 2));  // add x4,x3,x3
        tbl.push_back(mkv(mk(0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0), 0, 1, 0, 1));
        tbl.push_back(mkv(wb(4), 0, 0, 0, 0));
        tbl.push_back(mkv(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0), 0, 0, 0, 1));  // add x9
        tbl.push_back(mkv(mk(1, 9, 1, 0, 0, 10, 1, 1, 1, 0, 0, 0), 0, 1, 0, 0)); // kill
        tbl.push_back(mkv(mk(0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0));
        tbl.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 0, 0));  // kill, no undo
        tbl.push_back(mkv(mk(1, 0, 0, 0, 0, 8, 1, 3, 0, 1, 8, 0), 0, 0, 0, 1));  // issue+wb x8
        tbl.push_back(mkv(mk(1, 8, 1, 0, 0, 11, 1, 1, 0, 0, 0, 0), 1, 0, 0, 1));
        tbl.push_back(mkv(mk(1, 8, 1, 0, 0, 11, 1, 1, 0, 0, 0, 0), 1, 0, 0, 1));
        tbl.push_back(mkv(mk(1, 8, 1, 0, 0, 11, 1, 1, 0, 0, 0, 0), 0, 1, 0, 2));
        tbl.push_back(mkv(wb(8), 0, 0, 0, 1));
        tbl.push_back(mkv(wb(11), 0, 0, 0, 0));
        tbl.push_back(mkv(mk(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0), 0, 0, 0, 1));
        tbl.push_back(mkv(mk(1, 0, 0, 0, 0, 12, 1, 4, 0, 0, 0, 0), 0, 0, 0, 1));
        tbl.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12, 0), 0, 0, 0, 0)); // kill+wb
        tbl.push_back(mkv(mk(1, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0, 0), 0, 0, 0, 1));
        tbl.push_back(mkv(mk(1, 0, 0, 0, 0, 13, 1, 5, 0, 0, 0, 0), 0, 0, 0, 1));
        tbl.push_back(mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 0, 1));  // restore busy
        tbl.push_back(mkv(mk(1, 0, 0, 13, 1, 0, 1, 3, 0, 0, 0, 0), 0, 0, 1, 1)); // rd=x0 ignored
        tbl.push_back(mkv(wb(13), 0, 0, 0, 0));
        tbl.push_back(mkv(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 0, 0));

        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        chk("rst_busy_cnt", c_bc, 0);
        chk("rst_drained", c_dr, 1);
        cyc(mk(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("rst_stall", c_stall, 0);
        chk("rst_fwd1", c_f1, 0);
        chk("rst_fwd2", c_f2, 0);

        foreach (tbl[i]) begin
            cyc(tbl[i].s);
            chk($sformatf("tbl%0d_stall", i), c_stall, tbl[i].x_stall);
            chk($sformatf("tbl%0d_fwd1", i), c_f1, tbl[i].x_f1);
            chk($sformatf("tbl%0d_fwd2", i), c_f2, tbl[i].x_f2);
            chk($sformatf("tbl%0d_busy_cnt", i), c_bc, tbl[i].x_bc);
            chk($sformatf("tbl%0d_drained", i), c_dr, (tbl[i].x_bc == 0) ? 1 : 0);
        end

        // div x7 (lat 15) with a dependent reader held at decode
        cyc(mk(1, 0, 0, 0, 0, 7, 1, 15, 0, 0, 0, 0));
        n = 0; got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            cyc(mk(1, 7, 1, 0, 0, 14, 1, 1, 0, 0, 0, 0));
            if (c_stall == 1) n++;
            else begin got = 1; chk("div_fwd1", c_f1, 1); end
        end
        chk("div_accepted", got, 1);
        chk("div_stall_cycles", n, 14);
        cyc(wb(7)); cyc(wb(14));
        chk("div_drained", c_dr, 1);

        // div x2 (lat 10) followed by add x2 (lat 1)
        cyc(mk(1, 0, 0, 0, 0, 2, 1, 10, 0, 0, 0, 0));
        n = 0; got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            cyc(mk(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0, 0));
            if (c_stall == 1) n++;
            else got = 1;
        end
`ifdef SB_WAW_CHECK_EN
        exp_n = 9;
`else
        exp_n = 0;
`endif
        chk("waw_accepted", got, 1);
        chk("waw_stall_cycles", n, exp_n);
        cyc(mk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("waw_fwd1", c_f1, 1);
        cyc(wb(2));
        chk("waw_busy_cnt", c_bc, 0);

        // five long-latency writes in flight, then reset with a writeback pending
        for (int r = 1; r <= 5; r++) cyc(mk(1, 0, 0, 0, 0, r, 1, 8, 0, 0, 0, 0));
        chk("pre_rst_busy_cnt", c_bc, 5);
        chk("pre_rst_drained", c_dr, 0);
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        chk("mid_rst_busy_cnt", c_bc, 0);
        chk("mid_rst_drained", c_dr, 1);
        cyc(mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("mid_rst_stall", c_stall, 0);
        chk("mid_rst_fwd1", c_f1, 0);

        for (int k = 0; k < 3000; k++) begin
            s = mk(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 2) == 0),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 199) == 0));
            cyc(s);
            chk("rnd_stall", c_stall, e_stall);
            chk("rnd_fwd1", c_f1, e_f1);
            chk("rnd_fwd2", c_f2, e_f2);
            chk("rnd_busy_cnt", c_bc, m_count());
            chk("rnd_drained", c_dr, (m_count() == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
